mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single unified instruction/data memory between the multicycle CPU port and a DMA/loader port.
//   Sequences each access as a req/ack transaction so the CPU control FSM can stall on memory.
//   Round-robin arbitration, bounded DMA lock, and a timeout that terminates hung memory accesses with an error.
//   Sits between the CPU/DMA memory interfaces and the memory wrapper.
// PARAMETERS
//   ADDR_W    32  address width, byte address
//   DATA_W    32  data width; BE_W = DATA_W/8 byte enables
//   TIMEOUT   64  max cycles in WAIT before forced termination; must be >= 1
//   MAX_LOCK  8   max consecutive locked DMA grants while the CPU is waiting; must be >= 1
// PORTS
//   clk          in   1       clock, rising edge
//   rst          in   1       reset, asynchronous, active-high
//   cpu_req_i    in   1       CPU request; held until cpu_ack_o
//   cpu_we_i     in   1       CPU write (1) / read (0)
//   cpu_addr_i   in   ADDR_W  CPU address
//   cpu_wdata_i  in   DATA_W  CPU write data
//   cpu_be_i     in   BE_W    CPU byte enables
//   cpu_ack_o    out  1       one-cycle completion pulse
//   cpu_rdata_o  out  DATA_W  read data, valid while cpu_ack_o=1
//   dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i, dma_be_i   in    same widths/meaning as the cpu_* inputs
//   dma_lock_i   in   1       request to keep the grant for the next DMA transfer
//   dma_ack_o    out  1       one-cycle completion pulse
//   dma_rdata_o  out  DATA_W  read data, valid while dma_ack_o=1
//   mem_req_o    out  1       memory request; held until mem_ack_i
//   mem_we_o     out  1       memory write
//   mem_addr_o   out  ADDR_W  memory address
//   mem_wdata_o  out  DATA_W  memory write data
//   mem_be_o     out  BE_W    memory byte enables
//   mem_ack_i    in   1       memory done; mem_rdata_i valid in the same cycle
//   mem_rdata_i  in   DATA_W  memory read data
//   owner_o      out  1       current/last owner: 0 = CPU, 1 = DMA
//   err_o        out  1       one-cycle pulse, coincident with the ack of a timed-out transfer
// BEHAVIOUR
//   All outputs are registered.
//   Reset values:
//     - all outputs 0; state IDLE
//     - last_gnt = DMA, so the CPU wins the first tie
//     - wait_cnt = 0; lock_cnt = 0
//   FSM: IDLE -> WAIT -> DONE -> IDLE.
//   IDLE:
//     - no request: stay in IDLE
//     - single request: grant that requester
//     - both requesting: grant the port that is not last_gnt, except as below
//     - DMA keeps the grant when last_gnt = DMA, dma_lock_i = 1, dma_req_i = 1 and lock_cnt < MAX_LOCK
//   On grant:
//     - latch the winner's we/addr/wdata/be into the mem_* registers; mem_req_o = 1; go to WAIT
//     - owner_o = winner; last_gnt = winner
//     - lock_cnt increments on a locked DMA re-grant over a waiting CPU request; resets to 0 on any CPU grant
//   WAIT:
//     - mem_* outputs are held stable
//     - wait_cnt increments every cycle
//     - on mem_ack_i: capture mem_rdata_i, drop mem_req_o, go to DONE
//     - if wait_cnt reaches TIMEOUT-1 with no ack: drop mem_req_o, set rdata = 0, set err flag, go to DONE
//   DONE:
//     - owner's ack_o = 1 for exactly one cycle, with its rdata_o valid
//     - err_o = 1 if the transfer timed out
//     - clear wait_cnt; next state IDLE
//   Latency: request seen at cycle t, mem_req_o at t+1, mem_ack_i at t+1+L, ack_o at t+2+L.
//   Minimum access is 3 cycles; one transaction is outstanding at a time.
//   The requester samples ack_o and may drop its req or present the next request on the same edge.
//   IDLE never grants during DONE, so a stale req is never re-issued.
//   Rules:
//     - mem_ack_i outside WAIT is ignored.
//     - A late ack after a timeout is ignored.
//     - Inputs of the non-granted port are ignored.
//     - A requester that drops req mid-transaction is a protocol violation; the transaction still completes and acks.
//     - rdata_o of the non-owner stays 0; rdata_o returns to 0 after DONE.
//     - Write transfers return rdata = 0.
//     - Reset mid-operation aborts immediately: mem_req_o = 0, no ack generated.
// STRUCTURE
//   Include file mem_arb_defs.vh:
//     - state encodings ST_IDLE, ST_WAIT, ST_DONE (2 bits)
//     - OWN_CPU = 1'b0, OWN_DMA = 1'b1
//   Sub-module arb2_rr:
//     - combinational two-way round-robin pick with lock qualification
//     - inputs: req[1:0], last_gnt, lock_ok
//     - output: gnt[1:0], one-hot or zero
//   Top level holds the FSM, the wait/lock counters and the datapath registers.
// TESTING
//   1. CPU read only, mem acks after 2 cycles, addr 0x100, rdata 0xCAFEF00D
//      -> cpu_ack_o at t+4 with 0xCAFEF00D; dma_ack_o stays 0
//   2. CPU and DMA request in the same cycle after reset
//      -> CPU served first, then DMA; owner_o goes 0 then 1
//   3. Both requesting continuously, dma_lock_i = 0
//      -> grants strictly alternate CPU, DMA, CPU, DMA
//   4. dma_lock_i = 1, CPU waiting, MAX_LOCK = 8
//      -> DMA granted 9 times in a row (1 initial + 8 locked), then CPU; lock_cnt clears
//   5. mem_ack_i never asserted, TIMEOUT = 64
//      -> mem_req_o drops after 64 WAIT cycles; ack_o, err_o and rdata = 0 in the same cycle
//      -> a later spurious mem_ack_i is ignored
//   6. rst asserted in WAIT
//      -> mem_req_o = 0 immediately, no ack; after release, a new CPU request completes normally

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the CPU/DMA memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb2_rr.sv
// Two-way round-robin pick between CPU (bit 0) and DMA (bit 1).
// A DMA that held the last grant may keep it over a waiting CPU while lock_ok is set.
module arb2_rr
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       lock_ok,
  output logic [1:0] gnt
);

  // Combinational pick: single requester wins outright, a tie goes to the other port unless locked.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if ((last_gnt == OWN_DMA) && !lock_ok) gnt = 2'b01;
        else                                   gnt = 2'b10;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory between the CPU port and the DMA/loader port.
// One transaction in flight; each access runs IDLE -> WAIT -> DONE.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no transfer; arbitrate and latch the winner's request
//   ST_WAIT | mem_req_o held, waiting for mem_ack_i or the timeout
//   ST_DONE | one-cycle ack (and err on timeout) to the owner
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 64,
  parameter int MAX_LOCK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_W-1:0]     cpu_addr_i,
  input  logic [DATA_W-1:0]     cpu_wdata_i,
  input  logic [DATA_W/8-1:0]   cpu_be_i,
  output logic                  cpu_ack_o,
  output logic [DATA_W-1:0]     cpu_rdata_o,
  input  logic                  dma_req_i,
  input  logic                  dma_we_i,
  input  logic [ADDR_W-1:0]     dma_addr_i,
  input  logic [DATA_W-1:0]     dma_wdata_i,
  input  logic [DATA_W/8-1:0]   dma_be_i,
  input  logic                  dma_lock_i,
  output logic                  dma_ack_o,
  output logic [DATA_W-1:0]     dma_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic                  owner_o,
  output logic                  err_o
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam int LCNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);
  localparam logic [LCNT_W-1:0] LOCK_MAX  = LCNT_W'(MAX_LOCK);

  arb_state_t         state, state_nxt;
  logic               last_gnt;
  logic [WCNT_W-1:0]  wait_cnt;
  logic [LCNT_W-1:0]  lock_cnt;
  logic [1:0]         gnt;
  logic               win;
  logic               lock_ok;
  logic               do_grant;
  logic               do_finish;
  logic               timed_out;
  logic [DATA_W-1:0]  done_rdata;

  assign lock_ok = dma_lock_i && (lock_cnt < LOCK_MAX);
  assign win     = gnt[1];

  arb2_rr u_arb (
    .req      ({dma_req_i, cpu_req_i}),
    .last_gnt (last_gnt),
    .lock_ok  (lock_ok),
    .gnt      (gnt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and the one-cycle grant/finish strobes; a mem ack outside WAIT never gets here.
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_finish = 1'b0;
    timed_out = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          do_grant  = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ack_i) begin
          do_finish = 1'b1;
          state_nxt = ST_DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          do_finish = 1'b1;
          timed_out = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Writes and timed-out transfers return zero data.
  assign done_rdata = (timed_out || mem_we_o) ? '0 : mem_rdata_i;

  // Memory-side request registers, held stable from grant until the transfer ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      owner_o     <= OWN_CPU;
      last_gnt    <= OWN_DMA;
    end else if (do_grant) begin
      mem_req_o   <= 1'b1;
      mem_we_o    <= win ? dma_we_i    : cpu_we_i;
      mem_addr_o  <= win ? dma_addr_i  : cpu_addr_i;
      mem_wdata_o <= win ? dma_wdata_i : cpu_wdata_i;
      mem_be_o    <= win ? dma_be_i    : cpu_be_i;
      owner_o     <= win;
      last_gnt    <= win;
    end else if (do_finish) begin
      mem_req_o   <= 1'b0;
    end
  end

  // Wait timer and lock counter; lock_cnt only counts DMA re-grants taken over a waiting CPU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      lock_cnt <= '0;
    end else begin
      if (state == ST_WAIT)      wait_cnt <= wait_cnt + 1'b1;
      else if (state == ST_DONE) wait_cnt <= '0;
      if (do_grant) begin
        if (!win)
          lock_cnt <= '0;
        else if (cpu_req_i && (last_gnt == OWN_DMA))
          lock_cnt <= lock_cnt + 1'b1;
      end
    end
  end

  // Response registers: one-cycle ack/err to the owner, rdata zero outside that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_ack_o   <= 1'b0;
      dma_ack_o   <= 1'b0;
      cpu_rdata_o <= '0;
      dma_rdata_o <= '0;
      err_o       <= 1'b0;
    end else if (do_finish) begin
      cpu_ack_o   <= (owner_o == OWN_CPU);
      dma_ack_o   <= (owner_o == OWN_DMA);
      cpu_rdata_o <= (owner_o == OWN_CPU) ? done_rdata : '0;
      dma_rdata_o <= (owner_o == OWN_DMA) ? done_rdata : '0;
      err_o       <= timed_out;
    end else begin
      cpu_ack_o   <= 1'b0;
      dma_ack_o   <= 1'b0;
      cpu_rdata_o <= '0;
      dma_rdata_o <= '0;
      err_o       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scoreboard of expected grants/acks plus per-scenario tasks.
module tb_mem_port_arbiter;

  localparam int TO = 64;
  localparam int ML = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i;
  logic [3:0]  cpu_be_i;
  logic        cpu_ack_o;
  logic [31:0] cpu_rdata_o;
  logic        dma_req_i, dma_we_i, dma_lock_i;
  logic [31:0] dma_addr_i, dma_wdata_i;
  logic [3:0]  dma_be_i;
  logic        dma_ack_o;
  logic [31:0] dma_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        owner_o, err_o;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_be_i(cpu_be_i),
    .cpu_ack_o(cpu_ack_o), .cpu_rdata_o(cpu_rdata_o),
    .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
    .dma_wdata_i(dma_wdata_i), .dma_be_i(dma_be_i), .dma_lock_i(dma_lock_i),
    .dma_ack_o(dma_ack_o), .dma_rdata_o(dma_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .owner_o(owner_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic        own;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  logic grant_log[$];
  exp_t mon_e;
  logic prev_mem_req;

  // arbitration reference state
  logic model_last;
  int   model_lock;

  // memory model controls
  int mem_lat = 1;
  bit mem_en = 1'b1;
  bit spurious = 1'b0;
  int mem_cnt = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hCAFE_F00D;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic logic [31:0] port_wdata(input logic own, input logic [31:0] a);
    return own ? (a ^ 32'h0F0F_0F0F) : ~a;
  endfunction

  task automatic push_exp(input logic own, input logic we, input logic [31:0] a, input logic [31:0] rd,
                          input logic err);
    exp_t e;
    e.own   = own;
    e.we    = we;
    e.be    = own ? 4'b0011 : 4'b1111;
    e.addr  = a;
    e.wdata = port_wdata(own, a);
    e.rdata = rd;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Memory responder: acks mem_lat cycles after mem_req_o rises, or injects one stray ack on request.
  initial begin
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        mem_cnt = 0;
      end else if (spurious) begin
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        spurious = 1'b0;
      end else if (mem_req_o && mem_en) begin
        if (mem_cnt >= mem_lat) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = mem_data(mem_addr_o);
        end else begin
          mem_cnt++;
        end
      end else if (!mem_req_o) begin
        mem_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: checks each grant against the head entry and pops it on the ack.
  initial begin
    prev_mem_req = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        prev_mem_req = 1'b0;
      end else begin
        if (mem_req_o && !prev_mem_req) begin
          grant_log.push_back(owner_o);
          tests_run++;
          if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL grant_unexpected: owner=%0d addr=%h, required no grant", owner_o, mem_addr_o);
          end else if (owner_o !== sb[0].own || mem_we_o !== sb[0].we || mem_be_o !== sb[0].be ||
                       mem_addr_o !== sb[0].addr || mem_wdata_o !== sb[0].wdata) begin
            tests_failed++;
            $display("FAIL grant_fields: got own=%0d we=%0d be=%h addr=%h wdata=%h, required own=%0d we=%0d be=%h addr=%h wdata=%h",
                     owner_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
                     sb[0].own, sb[0].we, sb[0].be, sb[0].addr, sb[0].wdata);
          end
        end
        prev_mem_req = mem_req_o;
        if (cpu_ack_o || dma_ack_o) begin
          tests_run++;
          if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL ack_unexpected: cpu_ack=%0d dma_ack=%0d, required no ack", cpu_ack_o, dma_ack_o);
          end else begin
            mon_e = sb.pop_front();
            if (cpu_ack_o !== !mon_e.own || dma_ack_o !== mon_e.own || err_o !== mon_e.err ||
                (mon_e.own ? dma_rdata_o : cpu_rdata_o) !== mon_e.rdata ||
                (mon_e.own ? cpu_rdata_o : dma_rdata_o) !== 32'h0) begin
              tests_failed++;
              $display("FAIL ack_fields: got cpu_ack=%0d dma_ack=%0d err=%0d cpu_rdata=%h dma_rdata=%h, required owner=%0d err=%0d rdata=%h",
                       cpu_ack_o, dma_ack_o, err_o, cpu_rdata_o, dma_rdata_o, mon_e.own, mon_e.err, mon_e.rdata);
            end
          end
        end else if (err_o !== 1'b0 || cpu_rdata_o !== 32'h0 || dma_rdata_o !== 32'h0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL idle_outputs: err=%0d cpu_rdata=%h dma_rdata=%h, required all 0", err_o, cpu_rdata_o, dma_rdata_o);
        end
      end
    end
  end

  task automatic idle_inputs();
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0; cpu_be_i = '0;
    dma_req_i = 1'b0; dma_we_i = 1'b0; dma_addr_i = '0; dma_wdata_i = '0; dma_be_i = '0;
    dma_lock_i = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    sb.delete();
    grant_log.delete();
    model_last = 1'b1;
    model_lock = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives both ports with back-to-back requests; expected order comes from the arbitration rules.
  task automatic run_traffic(input int n_cpu, input int n_dma, input logic lock, input logic we,
                             input logic [31:0] cpu_base, input logic [31:0] dma_base);
    int rc, rd, ci, di, pc, pd, cyc;
    logic g_dma;
    logic [31:0] a;
    rc = n_cpu; rd = n_dma; pc = 0; pd = 0;
    while (rc > 0 || rd > 0) begin
      if (rc > 0 && rd > 0) begin
        if (model_last && lock && model_lock < ML) begin
          g_dma = 1'b1;
          model_lock++;
        end else begin
          g_dma = !model_last;
        end
      end else begin
        g_dma = (rd > 0);
      end
      if (!g_dma) model_lock = 0;
      model_last = g_dma;
      if (g_dma) begin a = dma_base + 32'(4 * pd); pd++; rd--; end
      else       begin a = cpu_base + 32'(4 * pc); pc++; rc--; end
      push_exp(g_dma, we, a, we ? 32'h0 : mem_data(a), 1'b0);
    end
    @(posedge clk); #1;
    ci = 0; di = 0;
    cpu_we_i = we; cpu_be_i = 4'b1111; cpu_addr_i = cpu_base; cpu_wdata_i = port_wdata(1'b0, cpu_base);
    dma_we_i = we; dma_be_i = 4'b0011; dma_addr_i = dma_base; dma_wdata_i = port_wdata(1'b1, dma_base);
    dma_lock_i = lock;
    cpu_req_i = (n_cpu > 0);
    dma_req_i = (n_dma > 0);
    cyc = 0;
    while ((ci < n_cpu || di < n_dma) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (cpu_ack_o) begin
        ci++;
        if (ci < n_cpu) begin
          cpu_addr_i = cpu_base + 32'(4 * ci);
          cpu_wdata_i = port_wdata(1'b0, cpu_addr_i);
        end else cpu_req_i = 1'b0;
      end
      if (dma_ack_o) begin
        di++;
        if (di < n_dma) begin
          dma_addr_i = dma_base + 32'(4 * di);
          dma_wdata_i = port_wdata(1'b1, dma_addr_i);
        end else dma_req_i = 1'b0;
      end
    end
    idle_inputs();
    @(posedge clk); #1;
    tests_run++;
    if (ci != n_cpu || di != n_dma || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL traffic_complete: cpu_acks=%0d dma_acks=%0d pending=%0d, required cpu_acks=%0d dma_acks=%0d pending=0",
               ci, di, sb.size(), n_cpu, n_dma);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    tests_run++;
    if (cpu_ack_o !== 1'b0 || dma_ack_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_acks: cpu_ack=%0d dma_ack=%0d, required 0 0", cpu_ack_o, dma_ack_o);
    end
    tests_run++;
    if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mem_bus: req=%0d we=%0d addr=%h, required all 0", mem_req_o, mem_we_o, mem_addr_o);
    end
    tests_run++;
    if (owner_o !== 1'b0 || err_o !== 1'b0 || cpu_rdata_o !== 32'h0 || dma_rdata_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_status: owner=%0d err=%0d cpu_rdata=%h dma_rdata=%h, required all 0",
               owner_o, err_o, cpu_rdata_o, dma_rdata_o);
    end
    apply_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (mem_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle_no_req: mem_req=%0d, required 0", mem_req_o);
    end
  endtask

  task automatic test_cpu_read();
    int k, dma_acks;
    bit seen;
    mem_lat = 2;
    push_exp(1'b0, 1'b0, 32'h0000_0100, 32'hCAFE_F00D, 1'b0);
    model_last = 1'b0;
    model_lock = 0;
    @(posedge clk); #1;
    cpu_we_i = 1'b0; cpu_be_i = 4'b1111; cpu_addr_i = 32'h0000_0100;
    cpu_wdata_i = port_wdata(1'b0, 32'h0000_0100);
    cpu_req_i = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (mem_req_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL cpu_read_req_latency: mem_req at t+1=%0d, required 1", mem_req_o);
    end
    k = 1; seen = 1'b0; dma_acks = 0;
    while (!seen && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (dma_ack_o) dma_acks++;
      if (cpu_ack_o) seen = 1'b1;
    end
    cpu_req_i = 1'b0;
    tests_run++;
    if (!seen || k != 4) begin
      tests_failed++;
      $display("FAIL cpu_read_ack_latency: ack at t+%0d (seen=%0d), required t+4", k, seen);
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (dma_ack_o) dma_acks++;
    end
    tests_run++;
    if (dma_acks != 0) begin
      tests_failed++;
      $display("FAIL cpu_read_dma_quiet: dma acks=%0d, required 0", dma_acks);
    end
    mem_lat = 1;
  endtask

  task automatic test_tie_after_reset();
    apply_reset();
    run_traffic(1, 1, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_8000);
    tests_run++;
    if (grant_log.size() != 2 || grant_log[0] !== 1'b0 || grant_log[1] !== 1'b1 || owner_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL tie_order: grants=%0d first=%0d owner=%0d, required 2 grants CPU then DMA, owner 1",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : 1'bx, owner_o);
    end
  endtask

  task automatic test_alternate();
    int bad;
    grant_log.delete();
    mem_lat = 0;
    run_traffic(4, 4, 1'b0, 1'b0, 32'h0000_2000, 32'h0000_9000);
    bad = 0;
    for (int i = 0; i < grant_log.size(); i++)
      if (grant_log[i] !== logic'(i % 2)) bad++;
    tests_run++;
    if (grant_log.size() != 8 || bad != 0) begin
      tests_failed++;
      $display("FAIL alternate_order: grants=%0d out_of_order=%0d, required 8 grants C,D,C,D,...", grant_log.size(), bad);
    end
    mem_lat = 3;
    run_traffic(2, 2, 1'b0, 1'b1, 32'h0000_3000, 32'h0000_A000);
    mem_lat = 1;
  endtask

  task automatic test_lock();
    int dma_run;
    run_traffic(1, 0, 1'b0, 1'b0, 32'h0000_4000, 32'h0000_0000);
    grant_log.delete();
    run_traffic(2, 12, 1'b1, 1'b0, 32'h0000_4100, 32'h0000_B000);
    dma_run = 0;
    while (dma_run < grant_log.size() && grant_log[dma_run] === 1'b1) dma_run++;
    tests_run++;
    if (dma_run != 9 || grant_log.size() < 10) begin
      tests_failed++;
      $display("FAIL lock_run: leading DMA grants=%0d total=%0d, required 9 then CPU", dma_run, grant_log.size());
    end
    tests_run++;
    if (grant_log.size() != 14 || grant_log[10] !== 1'b1 || grant_log[13] !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_after_clear: grants=%0d, required 14 with DMA re-lock after the CPU grant", grant_log.size());
    end
  endtask

  task automatic test_timeout();
    int n, acks;
    mem_en = 1'b0;
    push_exp(1'b0, 1'b0, 32'h0000_0200, 32'h0, 1'b1);
    model_last = 1'b0;
    model_lock = 0;
    @(posedge clk); #1;
    cpu_we_i = 1'b0; cpu_be_i = 4'b1111; cpu_addr_i = 32'h0000_0200;
    cpu_wdata_i = port_wdata(1'b0, 32'h0000_0200);
    cpu_req_i = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (mem_req_o === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    cpu_req_i = 1'b0;
    tests_run++;
    if (n != TO) begin
      tests_failed++;
      $display("FAIL timeout_length: mem_req held %0d cycles, required %0d", n, TO);
    end
    tests_run++;
    if (cpu_ack_o !== 1'b1 || err_o !== 1'b1 || cpu_rdata_o !== 32'h0 || dma_ack_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_response: cpu_ack=%0d err=%0d rdata=%h dma_ack=%0d, required 1 1 0 0",
               cpu_ack_o, err_o, cpu_rdata_o, dma_ack_o);
    end
    spurious = 1'b1;
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (cpu_ack_o || dma_ack_o || err_o || mem_req_o) acks++;
    end
    tests_run++;
    if (acks != 0) begin
      tests_failed++;
      $display("FAIL timeout_late_ack: %0d cycles with activity, required 0", acks);
    end
    mem_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int acks;
    mem_en = 1'b0;
    push_exp(1'b0, 1'b0, 32'h0000_0300, 32'h0, 1'b0);
    @(posedge clk); #1;
    cpu_we_i = 1'b0; cpu_be_i = 4'b1111; cpu_addr_i = 32'h0000_0300;
    cpu_wdata_i = port_wdata(1'b0, 32'h0000_0300);
    cpu_req_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (mem_req_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_in_wait: mem_req=%0d, required 1", mem_req_o);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (mem_req_o !== 1'b0 || cpu_ack_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_abort: mem_req=%0d cpu_ack=%0d, required 0 0", mem_req_o, cpu_ack_o);
    end
    sb.delete();
    idle_inputs();
    model_last = 1'b1;
    model_lock = 0;
    mem_en = 1'b1;
    acks = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (cpu_ack_o || dma_ack_o || mem_req_o) acks++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (cpu_ack_o || dma_ack_o || mem_req_o) acks++;
    end
    tests_run++;
    if (acks != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_ack: %0d cycles with ack/req, required 0", acks);
    end
    run_traffic(1, 0, 1'b0, 1'b0, 32'h0000_5000, 32'h0000_0000);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_tie_after_reset();
    test_alternate();
    test_lock();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
